// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared definitions for the framebuffer port arbiter.
//   - arb_state_e : arbiter state (clear sweep, normal run)
//   - FB_*        : default framebuffer geometry, shared with the panel
//                   timing generator and the compute engines
//   - clog2       : constant-evaluable ceil(log2) helper for widths
package fb_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  localparam int FB_DATA_W = 24;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DEPTH  = 384000;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: NUM_REQ-way round-robin arbiter with a one-hot grant.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   req_i     : per-requester request vector
//   advance_i : the offered grant was taken; move the pointer to it
//   gnt_o     : one-hot grant candidate (combinational, zero if no request)
// The pointer names the most recently served requester. The search starts
// just after it, so after reset (pointer = NUM_REQ-1) requester 0 goes first.
module rr_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   idx;
  logic               found;

  // Scan the requesters in order starting one past the pointer, wrapping,
  // and take the first one that is asking.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = idx;
      end
    end
    if (!advance_i) begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single-port framebuffer arbiter.
// After reset it sweeps CLEAR_VAL over addresses 0..DEPTH-1, then grants one
// memory access per cycle: the scanout read has fixed priority, the NUM_WR
// compute writers share the remaining slots round-robin.
//   i_CLK, i_RSTn         : clock / asynchronous active-low reset
//   i_RdReq, i_RdAddr     : scanout read request and address
//   o_RdGnt               : read granted this cycle (combinational)
//   o_RdData, o_RdValid   : read return, valid RD_LAT cycles after the command
//   i_WrReq/i_WrAddr/i_WrData : packed per-writer requests
//   o_WrGnt               : one-hot writer grant (combinational)
//   o_MemEn/We/Addr/WData : registered memory command
//   i_MemRData            : memory read data
//   o_Ready               : clear sweep finished
// Build option: define FB_ARB_STARVE_EN to force a write slot once writers
// have been blocked for STARVE_LIMIT consecutive cycles.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int                NUM_WR       = 4,
  parameter int                ADDR_W       = FB_ADDR_W,
  parameter int                DATA_W       = FB_DATA_W,
  parameter int                DEPTH        = FB_DEPTH,
  parameter int                RD_LAT       = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0,
  parameter int                STARVE_LIMIT = 64
) (
  input  logic                     i_CLK,
  input  logic                     i_RSTn,
  input  logic                     i_RdReq,
  input  logic [ADDR_W-1:0]        i_RdAddr,
  output logic                     o_RdGnt,
  output logic [DATA_W-1:0]        o_RdData,
  output logic                     o_RdValid,
  input  logic [NUM_WR-1:0]        i_WrReq,
  input  logic [NUM_WR*ADDR_W-1:0] i_WrAddr,
  input  logic [NUM_WR*DATA_W-1:0] i_WrData,
  output logic [NUM_WR-1:0]        o_WrGnt,
  output logic                     o_MemEn,
  output logic                     o_MemWe,
  output logic [ADDR_W-1:0]        o_MemAddr,
  output logic [DATA_W-1:0]        o_MemWData,
  input  logic [DATA_W-1:0]        i_MemRData,
  output logic                     o_Ready
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
  logic              memEn_q, memEn_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWData_q, memWData_d;
  logic [RD_LAT:0]   rdTag_q;

  logic              anyWr;
  logic              forceWr;
  logic              rdGnt;
  logic [NUM_WR-1:0] wrGnt;
  logic [NUM_WR-1:0] rrGnt;
  logic              wrAdvance;
  logic [ADDR_W-1:0] wrSelAddr;
  logic [DATA_W-1:0] wrSelData;

  assign anyWr     = |i_WrReq;
  assign wrAdvance = |wrGnt;

  rr_arbiter #(
    .NUM_REQ (NUM_WR)
  ) u_rr (
    .clk_i     (i_CLK),
    .rst_ni    (i_RSTn),
    .req_i     (i_WrReq),
    .advance_i (wrAdvance),
    .gnt_o     (rrGnt)
  );

`ifdef FB_ARB_STARVE_EN
  localparam int CNT_W = clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

  // The counter tops out at STARVE_LIMIT: in that cycle a write is forced,
  // which clears it again.
  assign forceWr = anyWr && (starveCnt_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (state_q == ST_RUN) begin
      if (wrAdvance || !anyWr) begin
        starveCnt_d = '0;
      end else begin
        starveCnt_d = starveCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  // No legal limit is negative, so the read port keeps absolute priority.
  assign forceWr = anyWr && (STARVE_LIMIT < 0);
`endif

  // One grant per cycle, only once the clear sweep is done.
  always_comb begin
    rdGnt = 1'b0;
    wrGnt = '0;
    if (state_q == ST_RUN) begin
      if (i_RdReq && !forceWr) begin
        rdGnt = 1'b1;
      end else if (anyWr) begin
        wrGnt = rrGnt;
      end
    end
  end

  always_comb begin
    wrSelAddr = '0;
    wrSelData = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wrGnt[k]) begin
        wrSelAddr = i_WrAddr[k*ADDR_W +: ADDR_W];
        wrSelData = i_WrData[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next memory command; the command is registered, so a
  // grant in this cycle shows on o_Mem* in the next one.
  always_comb begin
    state_d    = state_q;
    clrAddr_d  = clrAddr_q;
    memEn_d    = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = '0;
    memWData_d = '0;
    case (state_q)
      ST_CLEAR: begin
        memEn_d    = 1'b1;
        memWe_d    = 1'b1;
        memAddr_d  = clrAddr_q;
        memWData_d = CLEAR_VAL;
        clrAddr_d  = clrAddr_q + 1'b1;
        if (clrAddr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rdGnt) begin
          memEn_d   = 1'b1;
          memAddr_d = i_RdAddr;
        end else if (wrAdvance) begin
          memEn_d    = 1'b1;
          memWe_d    = 1'b1;
          memAddr_d  = wrSelAddr;
          memWData_d = wrSelData;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // rdTag_q[0] marks a read command on the bus; the tag then rides along
  // for RD_LAT more cycles to line up with the memory's return data.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q    <= ST_CLEAR;
      clrAddr_q  <= '0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWData_q <= '0;
      rdTag_q    <= '0;
    end else begin
      state_q    <= state_d;
      clrAddr_q  <= clrAddr_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWData_q <= memWData_d;
      rdTag_q    <= {rdTag_q[RD_LAT-1:0], rdGnt};
    end
  end

  assign o_RdGnt    = rdGnt;
  assign o_WrGnt    = wrGnt;
  assign o_RdData   = i_MemRData;
  assign o_RdValid  = rdTag_q[RD_LAT];
  assign o_MemEn    = memEn_q;
  assign o_MemWe    = memWe_q;
  assign o_MemAddr  = memAddr_q;
  assign o_MemWData = memWData_q;
  assign o_Ready    = (state_q == ST_RUN);

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Single-port framebuffer arbiter between the LCD scanout prefetch (read) and NUM_WR fractal compute engines (write).
- On reset it clears the framebuffer. It then grants one memory access per cycle:
  - the read port has fixed priority;
  - writers share the remaining slots round-robin.
- Sits between the compute cluster and the panel timing generator. It keeps the read path deterministic so scanout never underruns.

Parameters:
- NUM_WR, 4, number of write requesters (2..8).
- ADDR_W, 19, framebuffer word address width.
- DATA_W, 24, pixel width (RGB888).
- DEPTH, 384000, framebuffer words (800x480); clear sweep covers 0..DEPTH-1.
- RD_LAT, 1, memory read latency in cycles (1..4).
- CLEAR_VAL, 24'h000000, value written during the clear sweep.
- STARVE_LIMIT, 64, consecutive blocked-writer cycles before a forced write slot (optional feature only).

Ports:
- i_CLK  in  1  single clock; all logic rising-edge.
- i_RSTn  in  1  asynchronous active-low reset.
- i_RdReq  in  1  read request; held until granted.
- i_RdAddr  in  ADDR_W  read address; stable while i_RdReq is high.
- o_RdGnt  out  1  read granted this cycle (combinational).
- o_RdData  out  DATA_W  read data (passthrough of i_MemRData).
- o_RdValid  out  1  o_RdData valid.
- i_WrReq  in  NUM_WR  per-writer request; held until granted.
- i_WrAddr  in  NUM_WR*ADDR_W  packed addresses; writer k occupies bits [k*ADDR_W +: ADDR_W].
- i_WrData  in  NUM_WR*DATA_W  packed data, same packing.
- o_WrGnt  out  NUM_WR  one-hot write grant (combinational).
- o_MemEn, o_MemWe  out  1  registered memory command.
- o_MemAddr  out  ADDR_W  registered memory address.
- o_MemWData  out  DATA_W  registered memory write data.
- i_MemRData  in  DATA_W  memory read data.
- o_Ready  out  1  high once the clear sweep is complete.

Behaviour:
- Reset values: o_Mem* all 0, o_RdValid 0, o_Ready 0, state CLEAR, clear address 0, round-robin pointer NUM_WR-1 (writer 0 first).
- Reset asserted mid-sweep or mid-run aborts everything. Read tags in flight are discarded (o_RdValid 0).
- State machine:
  - CLEAR: every cycle issues a write of CLEAR_VAL to the clear address and increments it. No grants are given. After the cycle issuing DEPTH-1, go to RUN.
  - RUN: o_Ready=1 and stays there until reset.
- Arbitration in RUN, evaluated every cycle:
  - If i_RdReq, grant the read.
  - Otherwise, if any i_WrReq, grant exactly one writer: the first requesting index after the pointer, with wrap-around. Update the pointer to that writer.
  - The pointer changes only on a write grant.
- At most one grant per cycle. o_RdGnt and o_WrGnt are never both set.
- Memory command is registered: a grant in cycle N puts the command on o_Mem* in cycle N+1. Idle cycles drive o_MemEn=0.
- Read return: o_RdValid is high exactly in cycle N+1+RD_LAT for a read granted in cycle N. This uses a shift-register tag, so back-to-back reads are fully pipelined at one per cycle.
- Writes produce no return.
- Requests arriving during CLEAR wait; they are not dropped.
- A write and a read to the same address in consecutive grants are ordered by grant cycle.

Optional Feature:
- Macro FB_ARB_STARVE_EN.
- Defined:
  - A counter increments in each RUN cycle where any i_WrReq is high and no write is granted.
  - It clears on a write grant or when no writer is requesting.
  - When it equals STARVE_LIMIT, that cycle grants the round-robin writer even if i_RdReq is high. The read waits one cycle. The counter clears.
- Undefined: the read port has absolute priority, and the counter logic is absent.

Decomposition:
- Package fb_arb_pkg holds:
  - state enum (CLEAR, RUN);
  - default DATA_W/ADDR_W/DEPTH constants shared with the panel timing generator and the compute engines;
  - a clog2 helper.
- One sub-module, rr_arbiter: parameterised NUM_WR round-robin one-hot grant with pointer register and advance-on-grant input. It is reused for the compute-engine job dispatcher.

Test Plan:
- Clear sweep, DEPTH=16:
  - Memory sees 16 writes of CLEAR_VAL to addresses 0..15 on consecutive cycles.
  - o_Ready rises the cycle after the address-15 command.
  - No grants while o_Ready=0.
- Read latency, RD_LAT=2:
  - Read of addr 5 granted at cycle N; o_Mem* shows addr 5 with We=0 at N+1.
  - o_RdValid at N+3 only.
  - Three back-to-back reads give three consecutive valid cycles.
- Round robin:
  - i_WrReq=4'b1111 held, no read: grants cycle 0001, 0010, 0100, 1000, 0001.
  - Then drop writer 1: next sequence skips 0010.
- Read priority:
  - i_RdReq and i_WrReq=4'b0100 in the same cycle: o_RdGnt=1, o_WrGnt=0.
  - Writer 2 is granted the first cycle i_RdReq is low.
- Starvation (FB_ARB_STARVE_EN, STARVE_LIMIT=4):
  - i_RdReq held high with i_WrReq=4'b0001: the write is granted on the 5th cycle, and the read resumes next cycle.
  - Without the macro, no write is granted while i_RdReq is held.
- Reset mid-operation:
  - Assert i_RSTn low during clear at address 7, and again in RUN with a read in flight.
  - All outputs return to reset values immediately; the clear restarts at 0; no stale o_RdValid appears.
